// File: rtl/bp_update_arbiter_if.sv
// Resolution-side and predictor-side signal bundle for bp_update_arbiter.
// The execute/recovery logic drives the master side; the arbiter is the slave.
interface bp_update_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int GHB_SIZE = 8,
  parameter int DEPTH    = 4,
  parameter int BMASK_W  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                x0_valid;
  logic [XLEN-1:0]     x0_pc;
  logic                x0_taken;
  logic [GHB_SIZE-1:0] x0_ghbr;
  logic [BMASK_W-1:0]  x0_bmask;

  logic                x1_valid;
  logic [XLEN-1:0]     x1_pc;
  logic                x1_taken;
  logic [GHB_SIZE-1:0] x1_ghbr;
  logic [BMASK_W-1:0]  x1_bmask;

  logic                squash_en;
  logic [BMASK_W-1:0]  squash_mask;
  logic                resolve_en;
  logic [BMASK_W-1:0]  resolve_mask;

  logic                in_ready;
  logic                pht_wb_en;
  logic [XLEN-1:0]     pht_wb_pc;
  logic                pht_wb_taken;
  logic [GHB_SIZE-1:0] pht_wb_ghbr;
  logic [CNT_W-1:0]    count;
  logic                drop_err;

  modport master (
    output x0_valid, x0_pc, x0_taken, x0_ghbr, x0_bmask,
    output x1_valid, x1_pc, x1_taken, x1_ghbr, x1_bmask,
    output squash_en, squash_mask, resolve_en, resolve_mask,
    input  in_ready, pht_wb_en, pht_wb_pc, pht_wb_taken, pht_wb_ghbr, count, drop_err
  );

  modport slave (
    input  x0_valid, x0_pc, x0_taken, x0_ghbr, x0_bmask,
    input  x1_valid, x1_pc, x1_taken, x1_ghbr, x1_bmask,
    input  squash_en, squash_mask, resolve_en, resolve_mask,
    output in_ready, pht_wb_en, pht_wb_pc, pht_wb_taken, pht_wb_ghbr, count, drop_err
  );
endinterface

// File: rtl/bp_update_arbiter.sv
// Two-lane branch-resolution queue feeding the gshare PHT's single update port.
// Entries carry branch-mask tags so wrong-path resolutions are killed in place.
module bp_update_arbiter #(
  parameter int XLEN     = 32,
  parameter int GHB_SIZE = 8,
  parameter int DEPTH    = 4,
  parameter int BMASK_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  bp_update_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0]    head_reg, head_next;
  logic [PTR_W-1:0]    tail_reg, tail_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                drop_err_reg, drop_err_next;

  logic                wb_en_reg;
  logic [XLEN-1:0]     wb_pc_reg;
  logic                wb_taken_reg;
  logic [GHB_SIZE-1:0] wb_ghbr_reg;

  logic                in_ready;
  logic [BMASK_W-1:0]  res_clr;
  logic                x0_squashed, x1_squashed;
  logic                wr0_en, wr1_en;
  logic [PTR_W-1:0]    wr0_idx, wr1_idx;
  logic [1:0]          enq_n;
  logic                pop, head_live, head_squashed, emit;

  // Slot storage is a register file: squash and resolve touch every slot at once.
  logic [DEPTH-1:0]    live_vec;
  logic [DEPTH-1:0]    taken_vec;
  logic [XLEN-1:0]     pc_arr    [DEPTH];
  logic [GHB_SIZE-1:0] ghbr_arr  [DEPTH];
  logic [BMASK_W-1:0]  bmask_arr [DEPTH];

  assign in_ready = (count_reg <= READY_MAX);

  always_comb begin
    res_clr     = bus.resolve_en ? bus.resolve_mask : '0;
    x0_squashed = bus.squash_en && (|(bus.x0_bmask & bus.squash_mask));
    x1_squashed = bus.squash_en && (|(bus.x1_bmask & bus.squash_mask));
    wr0_en      = in_ready && bus.x0_valid && !x0_squashed;
    wr1_en      = in_ready && bus.x1_valid && !x1_squashed;
    // Lane 1 packs directly behind lane 0 only when lane 0 actually took a slot.
    wr0_idx     = tail_reg;
    wr1_idx     = tail_reg + PTR_W'(wr0_en);
    enq_n       = 2'(wr0_en) + 2'(wr1_en);
    tail_next   = tail_reg + PTR_W'(enq_n);
  end

  always_comb begin
    pop           = (count_reg != '0);
    head_live     = live_vec[head_reg];
    head_squashed = bus.squash_en && (|(bmask_arr[head_reg] & bus.squash_mask));
    // Dead or just-squashed heads are still popped, as a reclaim bubble.
    emit          = pop && head_live && !head_squashed;
    head_next     = head_reg + PTR_W'(pop);
    count_next    = count_reg + CNT_W'(enq_n) - CNT_W'(pop);
    drop_err_next = drop_err_reg | ((bus.x0_valid | bus.x1_valid) & ~in_ready);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [PTR_W-1:0] SLOT_IDX = PTR_W'(gi);

      logic                live_reg;
      logic [XLEN-1:0]     pc_reg;
      logic                taken_reg;
      logic [GHB_SIZE-1:0] ghbr_reg;
      logic [BMASK_W-1:0]  bmask_reg;
      logic                wr0_hit, wr1_hit, squash_hit, popped;

      assign wr0_hit    = wr0_en && (wr0_idx == SLOT_IDX);
      assign wr1_hit    = wr1_en && (wr1_idx == SLOT_IDX);
      assign squash_hit = bus.squash_en && (|(bmask_reg & bus.squash_mask));
      assign popped     = pop && (head_reg == SLOT_IDX);

      // Write slots are always free (in_ready guarantees two), so a write never
      // collides with the squash/resolve update of an occupied slot.
      always_ff @(posedge clock) begin
        if (reset) begin
          live_reg  <= 1'b0;
          pc_reg    <= '0;
          taken_reg <= 1'b0;
          ghbr_reg  <= '0;
          bmask_reg <= '0;
        end else if (wr0_hit) begin
          live_reg  <= 1'b1;
          pc_reg    <= bus.x0_pc;
          taken_reg <= bus.x0_taken;
          ghbr_reg  <= bus.x0_ghbr;
          bmask_reg <= bus.x0_bmask & ~res_clr;
        end else if (wr1_hit) begin
          live_reg  <= 1'b1;
          pc_reg    <= bus.x1_pc;
          taken_reg <= bus.x1_taken;
          ghbr_reg  <= bus.x1_ghbr;
          bmask_reg <= bus.x1_bmask & ~res_clr;
        end else begin
          if (squash_hit || popped) begin
            live_reg <= 1'b0;
          end
          bmask_reg <= bmask_reg & ~res_clr;
        end
      end

      assign live_vec[gi]  = live_reg;
      assign taken_vec[gi] = taken_reg;
      assign pc_arr[gi]    = pc_reg;
      assign ghbr_arr[gi]  = ghbr_reg;
      assign bmask_arr[gi] = bmask_reg;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      drop_err_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      drop_err_reg <= drop_err_next;
    end
  end

  // Update payload holds its last value; a later squash cannot recall it.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_en_reg    <= 1'b0;
      wb_pc_reg    <= '0;
      wb_taken_reg <= 1'b0;
      wb_ghbr_reg  <= '0;
    end else begin
      wb_en_reg <= emit;
      if (emit) begin
        wb_pc_reg    <= pc_arr[head_reg];
        wb_taken_reg <= taken_vec[head_reg];
        wb_ghbr_reg  <= ghbr_arr[head_reg];
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.pht_wb_en    = wb_en_reg;
  assign bus.pht_wb_pc    = wb_pc_reg;
  assign bus.pht_wb_taken = wb_taken_reg;
  assign bus.pht_wb_ghbr  = wb_ghbr_reg;
  assign bus.count        = count_reg;
  assign bus.drop_err     = drop_err_reg;
endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: directed scenarios then random traffic, all
// checked every cycle against a queue-based model of the resolution buffer.
module tb_bp_update_arbiter;
  localparam int XLEN = 32, GHB_SIZE = 8, DEPTH = 4, BMASK_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bp_update_arbiter_if #(.XLEN(XLEN), .GHB_SIZE(GHB_SIZE), .DEPTH(DEPTH), .BMASK_W(BMASK_W)) bus ();

  bp_update_arbiter #(.XLEN(XLEN), .GHB_SIZE(GHB_SIZE), .DEPTH(DEPTH), .BMASK_W(BMASK_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [XLEN-1:0]     pc;
    logic                taken;
    logic [GHB_SIZE-1:0] ghbr;
    logic [BMASK_W-1:0]  bmask;
    bit                  live;
  } ent_t;

  ent_t                mq[$];
  bit                  m_wb_en;
  logic [XLEN-1:0]     m_pc;
  logic                m_taken;
  logic [GHB_SIZE-1:0] m_ghbr;
  bit                  m_drop;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.x0_valid = 0; bus.x0_pc = '0; bus.x0_taken = 0; bus.x0_ghbr = '0; bus.x0_bmask = '0;
    bus.x1_valid = 0; bus.x1_pc = '0; bus.x1_taken = 0; bus.x1_ghbr = '0; bus.x1_bmask = '0;
    bus.squash_en = 0; bus.squash_mask = '0; bus.resolve_en = 0; bus.resolve_mask = '0;
  endtask

  task automatic lane0(input logic [31:0] pc, input logic t, input logic [7:0] g, input logic [3:0] bm);
    bus.x0_valid = 1; bus.x0_pc = pc; bus.x0_taken = t; bus.x0_ghbr = g; bus.x0_bmask = bm;
  endtask

  task automatic lane1(input logic [31:0] pc, input logic t, input logic [7:0] g, input logic [3:0] bm);
    bus.x1_valid = 1; bus.x1_pc = pc; bus.x1_taken = t; bus.x1_ghbr = g; bus.x1_bmask = bm;
  endtask

  function automatic bit squash_hits(input logic [3:0] bm);
    return bus.squash_en && ((bm & bus.squash_mask) != 0);
  endfunction

  function automatic void accept(input logic [31:0] pc, input logic t, input logic [7:0] g, input logic [3:0] bm);
    ent_t e;
    if (squash_hits(bm)) return;
    e.pc = pc; e.taken = t; e.ghbr = g; e.live = 1;
    e.bmask = bus.resolve_en ? (bm & ~bus.resolve_mask) : bm;
    mq.push_back(e);
  endfunction

  // One clock of the buffer's rules, evaluated on the inputs about to be sampled.
  task automatic model_step();
    bit   rdy;
    ent_t e;
    rdy = (DEPTH - mq.size()) >= 2;
    m_wb_en = 0;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live && !squash_hits(e.bmask)) begin
        m_wb_en = 1; m_pc = e.pc; m_taken = e.taken; m_ghbr = e.ghbr;
      end
    end
    foreach (mq[i]) begin
      if (squash_hits(mq[i].bmask)) mq[i].live = 0;
      if (bus.resolve_en) mq[i].bmask = mq[i].bmask & ~bus.resolve_mask;
    end
    if ((bus.x0_valid || bus.x1_valid) && !rdy) m_drop = 1;
    if (rdy) begin
      if (bus.x0_valid) accept(bus.x0_pc, bus.x0_taken, bus.x0_ghbr, bus.x0_bmask);
      if (bus.x1_valid) accept(bus.x1_pc, bus.x1_taken, bus.x1_ghbr, bus.x1_bmask);
    end
  endtask

  task automatic compare_all();
    check("count", 64'(bus.count), 64'(mq.size()));
    check("in_ready", 64'(bus.in_ready), 64'((DEPTH - mq.size()) >= 2));
    check("pht_wb_en", 64'(bus.pht_wb_en), 64'(m_wb_en));
    check("pht_wb_pc", 64'(bus.pht_wb_pc), 64'(m_pc));
    check("pht_wb_taken", 64'(bus.pht_wb_taken), 64'(m_taken));
    check("pht_wb_ghbr", 64'(bus.pht_wb_ghbr), 64'(m_ghbr));
    check("drop_err", 64'(bus.drop_err), 64'(m_drop));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
    idle();
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    mq.delete();
    m_wb_en = 0; m_pc = '0; m_taken = 0; m_ghbr = '0; m_drop = 0;
    compare_all();
    idle();
  endtask

  initial begin
    idle();
    do_reset();

    // Single resolution: visible exactly two edges after it is presented.
    lane0(32'h100, 1, 8'h5A, 4'h0);
    cycle();
    cycle();
    check("single_en", 64'(bus.pht_wb_en), 64'd1);
    check("single_pc", 64'(bus.pht_wb_pc), 64'h100);
    check("single_ghbr", 64'(bus.pht_wb_ghbr), 64'h5A);
    cycle();
    check("single_drained", 64'(bus.count), 64'd0);

    // Dual burst: back-pressure after the second pair, four consecutive updates.
    lane0(32'h10, 0, 8'h01, 4'h0); lane1(32'h14, 1, 8'h02, 4'h0);
    cycle();
    lane0(32'h18, 1, 8'h03, 4'h0); lane1(32'h1C, 0, 8'h04, 4'h0);
    cycle();
    check("burst_in_ready", 64'(bus.in_ready), 64'd0);
    check("burst_first", 64'(bus.pht_wb_pc), 64'h10);
    repeat (4) cycle();
    check("burst_last", 64'(bus.pht_wb_pc), 64'h1C);
    check("burst_drop_err", 64'(bus.drop_err), 64'd0);

    // Overflow: fill until in_ready drops, then push one more.
    lane0(32'h20, 1, 8'h11, 4'h0); lane1(32'h24, 1, 8'h12, 4'h0);
    cycle();
    lane0(32'h28, 1, 8'h13, 4'h0); lane1(32'h2C, 1, 8'h14, 4'h0);
    cycle();
    lane0(32'hDEAD, 1, 8'hEE, 4'h0);
    cycle();
    check("overflow_drop_err", 64'(bus.drop_err), 64'd1);
    repeat (6) cycle();
    check("drop_err_sticky", 64'(bus.drop_err), 64'd1);
    do_reset();

    // Squash: head killed as it pops, and a non-head entry killed in place.
    lane0(32'h40, 1, 8'h21, 4'b0001); lane1(32'h44, 0, 8'h22, 4'b0010);
    cycle();
    bus.squash_en = 1; bus.squash_mask = 4'b0001;
    cycle();
    cycle();
    check("squash_survivor", 64'(bus.pht_wb_pc), 64'h44);
    lane0(32'h50, 1, 8'h31, 4'b0010); lane1(32'h54, 1, 8'h32, 4'b0001);
    cycle();
    lane0(32'h58, 0, 8'h33, 4'b0001);
    cycle();
    bus.squash_en = 1; bus.squash_mask = 4'b0001;
    cycle();
    check("squash_bubble", 64'(bus.pht_wb_en), 64'd0);
    repeat (3) cycle();
    check("squash_empty", 64'(bus.count), 64'd0);

    // Resolve clears the tag, so the following squash no longer hits it.
    lane0(32'h60, 0, 8'h41, 4'b0000); lane1(32'h64, 1, 8'h42, 4'b0011);
    cycle();
    bus.resolve_en = 1; bus.resolve_mask = 4'b0001;
    cycle();
    bus.squash_en = 1; bus.squash_mask = 4'b0001;
    cycle();
    check("resolved_emit", 64'(bus.pht_wb_en), 64'd1);
    check("resolved_pc", 64'(bus.pht_wb_pc), 64'h64);
    cycle();

    // Incoming entry on the path being squashed is never stored.
    lane1(32'h70, 1, 8'h51, 4'b0100);
    bus.squash_en = 1; bus.squash_mask = 4'b0100;
    cycle();
    check("same_cycle_squash", 64'(bus.count), 64'd0);

    // Reset with three entries queued discards everything.
    lane0(32'h80, 1, 8'h61, 4'h0); lane1(32'h84, 1, 8'h62, 4'h0);
    cycle();
    lane0(32'h88, 1, 8'h63, 4'h0); lane1(32'h8C, 1, 8'h64, 4'h0);
    cycle();
    check("pre_reset_count", 64'(bus.count), 64'd3);
    do_reset();
    cycle();
    check("post_reset_count", 64'(bus.count), 64'd0);
    check("post_reset_en", 64'(bus.pht_wb_en), 64'd0);

    // Random traffic with squash/resolve and the occasional reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(2) == 0)
          lane0($urandom, 1'($urandom), 8'($urandom), 4'($urandom_range(15)));
        if ($urandom_range(2) == 0)
          lane1($urandom, 1'($urandom), 8'($urandom), 4'($urandom_range(15)));
        if ($urandom_range(5) == 0) begin
          bus.squash_en = 1; bus.squash_mask = 4'(1 << $urandom_range(3));
        end
        if ($urandom_range(3) == 0) begin
          bus.resolve_en = 1; bus.resolve_mask = 4'(1 << $urandom_range(3));
        end
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
